vscale_hasti_sram: RTL and testbench
====================================

// Module: vscale_hasti_sram
// PURPOSE
//  AHB-Lite (HASTI) slave SRAM sitting directly downstream of a vscale_hasti_bridge
//  master port (imem or dmem side); consumes its address/data-phase transfers.
//  Provides word-organised storage with byte-lane writes, configurable wait states,
//  ERROR response for bad accesses and write-to-read forwarding for back-to-back ops.
// PARAMETERS
//  NWORDS       1024  depth in 32-bit words; valid byte addresses 0 .. 4*NWORDS-1
//  WAIT_STATES  0     extra hready-low cycles inserted in every OKAY data phase (0..15)
// PORTS
//  hclk       in   1   clock; all state changes on rising edge
//  reset      in   1   synchronous, active-high reset
//  haddr      in   32  address-phase byte address
//  hwrite     in   1   address-phase direction, 1 = write
//  hsize      in   3   0 = byte, 1 = half, 2 = word; >2 is an error
//  hburst     in   3   ignored
//  hmastlock  in   1   ignored
//  hprot      in   4   ignored
//  htrans     in   2   0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ
//  hwdata     in   32  write data, valid in the write data phase
//  hrdata     out  32  read data, valid when hready=1 in a read data phase
//  hready     out  1   1 = current data phase completes this cycle
//  hresp      out  1   0 OKAY, 1 ERROR
// BEHAVIOUR
//  Reset: hready=1, hresp=0, hrdata=0, no data phase pending, wait counter=0.
//   Array contents are not reset. Reset mid-transfer abandons it; a pending write is dropped.
//  Address phase accepted on a cycle with hready=1 and htrans[1]=1 (NONSEQ/SEQ).
//   Register word index haddr[31:2], byte offset haddr[1:0], hsize, hwrite and a
//   dp_valid flag. IDLE/BUSY with hready=1 clears dp_valid (zero-wait OKAY next cycle).
//  Error check at acceptance:
//   - hsize>2, or half with haddr[0]=1, or word with haddr[1:0]!=0
//   - or haddr >= 4*NWORDS
//   Any of these -> two-cycle ERROR:
//   - cycle 1: hready=0, hresp=1
//   - cycle 2: hready=1, hresp=1
//   No array write; hrdata=0.
//  Data-phase state machine:
//   - IDLE: hready=1, hresp=0.
//   - WAIT: hready=0, hresp=0. Entered if WAIT_STATES>0; down-counter loaded with
//     WAIT_STATES, exits when it reaches 1.
//   - DONE: hready=1, hresp=0.
//   - ERR1 -> ERR2: per the two-cycle ERROR above.
//   DONE/ERR2 may accept the next address phase in the same cycle (pipelined).
//  Write commit: on the completing (hready=1) cycle of an OKAY write data phase,
//   write hwdata to the enabled byte lanes:
//   - byte: lane = offset
//   - half: lanes offset, offset+1
//   - word: all 4 lanes
//   Other bytes of the word are unchanged.
//  Read: array read at address-phase acceptance; result latched in rdata_q and held
//   through all wait states; hrdata = rdata_q during an OKAY read data phase, else 0.
//   Full word is returned regardless of hsize (the master extracts lanes).
//  Forwarding: if a read is accepted in the same cycle a write commits to the same
//   word, rdata_q = old word with the written lanes replaced by hwdata lanes.
//  Back-to-back accepts: write, read, write in consecutive cycles; no bubbles when
//   WAIT_STATES=0. Read latency = 1 cycle after acceptance + WAIT_STATES.
// TESTING
//  1. Word write 0xDEADBEEF @0x10, idle, word read @0x10 (WAIT_STATES=0)
//     -> hrdata=0xDEADBEEF, hready=1 every cycle.
//  2. Word write 0x11223344 @0x20, then byte write 0xAA @0x22 (hwdata=0x00AA0000),
//     then read @0x20 issued the cycle after
//     -> forwarded hrdata=0x11AA3344.
//  3. WAIT_STATES=2, read @0x0
//     -> hready low exactly 2 cycles; hrdata stable and correct on the hready-high cycle.
//  4. Word access @0x2, half access @0x1, hsize=3, addr 4*NWORDS
//     -> each gives hready 0 then 1 with hresp=1 both cycles; memory unchanged on readback.
//  5. Reset asserted during WAIT of a write
//     -> hready=1/hresp=0 next cycle; target word keeps its old value.
//  6. htrans=BUSY then IDLE between transfers -> OKAY zero-wait, no array access.

Source files
------------

// File: rtl/vscale_hasti_sram.sv
// AHB-Lite (HASTI) slave SRAM: word storage with byte-lane writes, optional wait states,
// two-cycle ERROR responses and write-to-read forwarding for back-to-back transfers.
module vscale_hasti_sram #(
  parameter int unsigned NWORDS      = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        hclk,
  input  logic        reset,
  input  logic [31:0] haddr,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic        hmastlock,
  input  logic [3:0]  hprot,
  input  logic [1:0]  htrans,
  input  logic [31:0] hwdata,
  output logic [31:0] hrdata,
  output logic        hready,
  output logic        hresp
);

  localparam int unsigned IdxW = $clog2(NWORDS);
  localparam logic [32:0] ByteLimit = 33'(NWORDS) << 2;

  typedef enum logic [2:0] {StIdle, StWait, StDone, StErr1, StErr2} dp_state_e;

  dp_state_e        state_q;
  logic [3:0]       wait_cnt_q;
  logic [IdxW-1:0]  dp_idx_q;
  logic [1:0]       dp_off_q;
  logic [2:0]       dp_size_q;
  logic             dp_write_q;
  logic             dp_valid_q;
  logic [31:0]      rdata_q;
  logic [31:0]      mem [NWORDS];

  logic             accept;
  logic             acc_err;
  logic [IdxW-1:0]  acc_idx;
  logic             wr_commit;
  logic [3:0]       wr_be;
  logic [31:0]      rd_word;
  logic             unused_ok;

  assign unused_ok = ^{hburst, hmastlock, hprot, htrans[0]};

  assign hready = (state_q == StIdle) || (state_q == StDone) || (state_q == StErr2);
  assign hresp  = (state_q == StErr1) || (state_q == StErr2);
  assign hrdata = (dp_valid_q && !dp_write_q && (state_q == StWait || state_q == StDone))
                  ? rdata_q : '0;

  assign accept  = hready && htrans[1];
  assign acc_idx = haddr[IdxW+1:2];
  assign acc_err = (hsize > 3'd2)
                || (hsize == 3'd1 && haddr[0])
                || (hsize == 3'd2 && haddr[1:0] != 2'b00)
                || ({1'b0, haddr} >= ByteLimit);

  assign wr_commit = (state_q == StDone) && dp_valid_q && dp_write_q;

  always_comb begin
    wr_be = 4'b0000;
    case (dp_size_q)
      3'd0:    wr_be = 4'b0001 << dp_off_q;
      3'd1:    wr_be = 4'b0011 << dp_off_q;
      default: wr_be = 4'b1111;
    endcase
  end

  // A read accepted while a write to the same word commits sees the new lanes.
  always_comb begin
    rd_word = mem[acc_idx];
    if (wr_commit && dp_idx_q == acc_idx) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) rd_word[8*i +: 8] = hwdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (!reset && wr_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[dp_idx_q][8*i +: 8] <= hwdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (reset) begin
      state_q    <= StIdle;
      wait_cnt_q <= 4'd0;
      dp_idx_q   <= '0;
      dp_off_q   <= 2'b00;
      dp_size_q  <= 3'd0;
      dp_write_q <= 1'b0;
      dp_valid_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      case (state_q)
        StWait: begin
          if (wait_cnt_q <= 4'd1) begin
            state_q <= StDone;
          end else begin
            wait_cnt_q <= wait_cnt_q - 4'd1;
          end
        end
        StErr1: state_q <= StErr2;
        default: begin
          // Idle, Done and Err2 all present hready=1 and may take a new address phase.
          if (accept) begin
            dp_idx_q   <= acc_idx;
            dp_off_q   <= haddr[1:0];
            dp_size_q  <= hsize;
            dp_write_q <= hwrite;
            dp_valid_q <= 1'b1;
            if (acc_err) begin
              state_q <= StErr1;
            end else if (WAIT_STATES != 0) begin
              state_q    <= StWait;
              wait_cnt_q <= 4'(WAIT_STATES);
            end else begin
              state_q <= StDone;
            end
            if (!acc_err && !hwrite) rdata_q <= rd_word;
          end else begin
            dp_valid_q <= 1'b0;
            state_q    <= StIdle;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vscale_hasti_sram.sv
// Bench for vscale_hasti_sram: two instances (0 and 2 wait states) driven by a bus master task,
// with a transaction-level memory model feeding per-instance scoreboard queues.
module tb_vscale_hasti_sram;

  localparam int unsigned NW = 64;

  typedef struct {
    bit          err;
    bit          rd;
    logic [31:0] data;
    int          low;
  } exp_t;

  logic        hclk = 1'b0;
  logic        reset  [2];
  logic [31:0] haddr  [2];
  logic        hwrite [2];
  logic [2:0]  hsize  [2];
  logic [1:0]  htrans [2];
  logic [31:0] hwdata [2];
  logic [31:0] hrdata [2];
  logic        hready [2];
  logic        hresp  [2];

  logic [31:0] model [2][NW];
  exp_t        sb0[$];
  exp_t        sb1[$];
  int          total = 0;
  int          bad = 0;
  int          low [2] = '{0, 0};

  always #5 hclk = ~hclk;

  vscale_hasti_sram #(.NWORDS(NW), .WAIT_STATES(0)) u_dut0 (
    .hclk(hclk), .reset(reset[0]), .haddr(haddr[0]), .hwrite(hwrite[0]), .hsize(hsize[0]),
    .hburst(3'b000), .hmastlock(1'b0), .hprot(4'b0011), .htrans(htrans[0]),
    .hwdata(hwdata[0]), .hrdata(hrdata[0]), .hready(hready[0]), .hresp(hresp[0])
  );

  vscale_hasti_sram #(.NWORDS(NW), .WAIT_STATES(2)) u_dut2 (
    .hclk(hclk), .reset(reset[1]), .haddr(haddr[1]), .hwrite(hwrite[1]), .hsize(hsize[1]),
    .hburst(3'b000), .hmastlock(1'b0), .hprot(4'b0011), .htrans(htrans[1]),
    .hwdata(hwdata[1]), .hrdata(hrdata[1]), .hready(hready[1]), .hresp(hresp[1])
  );

  task automatic chk(input string name, input int d, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s dut=%0d actual=%h required=%h", name, d, act, req);
    end
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? sb0.size() : sb1.size();
  endfunction

  // Transaction-level reference: what the slave must answer for one address phase.
  function automatic exp_t model_step(input int d, input logic [1:0] tr, input logic wr,
                                      input logic [2:0] sz, input logic [31:0] addr,
                                      input logic [31:0] wd);
    exp_t e;
    int   nb;
    int   off;
    int   idx;
    e.err = 0; e.rd = 0; e.data = '0; e.low = (d == 0) ? 0 : 2;
    if (!tr[1]) begin
      e.low = 0;
      return e;
    end
    nb  = (sz <= 3'd2) ? (1 << sz) : 1;
    off = int'(addr[1:0]);
    if (sz > 3'd2 || (off % nb) != 0 || addr >= 32'(4 * NW)) begin
      e.err = 1;
      e.low = 1;
      return e;
    end
    idx = int'(addr >> 2);
    if (wr) begin
      for (int l = 0; l < 4; l++) begin
        if (l >= off && l < off + nb) model[d][idx][8*l +: 8] = wd[8*l +: 8];
      end
    end else begin
      e.rd   = 1;
      e.data = model[d][idx];
    end
    return e;
  endfunction

  // Called #1 after a rising edge; returns #1 after the edge that accepted the address phase.
  task automatic issue(input int d, input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                       input logic [31:0] addr, input logic [31:0] wd, input bit modelled);
    exp_t e;
    int   guard;
    htrans[d] = tr; hwrite[d] = wr; hsize[d] = sz; haddr[d] = addr;
    guard = 0;
    while (hready[d] !== 1'b1 && guard < 40) begin
      @(posedge hclk); #1;
      guard++;
    end
    if (guard >= 40) begin
      total++; bad++;
      $display("FAIL accept_timeout dut=%0d actual=hready_low required=hready_high", d);
    end
    if (modelled) e = model_step(d, tr, wr, sz, addr, wd);
    @(posedge hclk); #1;
    hwdata[d] = wd;
    if (modelled) begin
      if (d == 0) sb0.push_back(e);
      else sb1.push_back(e);
    end
  endtask

  always @(negedge hclk) begin : monitor
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (reset[d] || qsize(d) == 0) begin
        low[d] = 0;
      end else if (hready[d] !== 1'b1) begin
        low[d]++;
        e = (d == 0) ? sb0[0] : sb1[0];
        chk("hresp_wait", d, 32'(hresp[d]), 32'(e.err));
      end else begin
        e = (d == 0) ? sb0.pop_front() : sb1.pop_front();
        chk("wait_cycles", d, 32'(low[d]), 32'(e.low));
        chk("hresp", d, 32'(hresp[d]), 32'(e.err));
        chk("hrdata", d, hrdata[d], e.rd ? e.data : 32'h0);
        low[d] = 0;
      end
    end
  end

  initial begin
    logic [1:0]  tr;
    logic [2:0]  sz;
    logic [31:0] addr;
    int          r;
    for (int d = 0; d < 2; d++) begin
      reset[d] = 1'b1; htrans[d] = 2'd0; hwrite[d] = 1'b0; hsize[d] = 3'd2;
      haddr[d] = '0; hwdata[d] = '0;
    end
    repeat (3) @(posedge hclk);
    #1;
    reset[0] = 1'b0; reset[1] = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk("reset_hready", d, 32'(hready[d]), 32'h1);
      chk("reset_hresp", d, 32'(hresp[d]), 32'h0);
      chk("reset_hrdata", d, hrdata[d], 32'h0);
    end

    // Give every word a known value through the bus.
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < int'(NW); i++) issue(d, 2'd2, 1'b1, 3'd2, 32'(4 * i), $urandom, 1);

    // Word write, idle, read back.
    issue(0, 2'd2, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1);
    issue(0, 2'd0, 1'b0, 3'd2, 32'h0, 32'h0, 1);
    issue(0, 2'd2, 1'b0, 3'd2, 32'h10, 32'h0, 1);
    // Byte write forwarded into an immediately following read.
    issue(0, 2'd2, 1'b1, 3'd2, 32'h20, 32'h11223344, 1);
    issue(0, 2'd3, 1'b1, 3'd0, 32'h22, 32'h00AA0000, 1);
    issue(0, 2'd3, 1'b0, 3'd2, 32'h20, 32'h0, 1);
    // Bad accesses, then readback of the words they pointed at.
    issue(0, 2'd2, 1'b1, 3'd2, 32'h2, 32'hFFFFFFFF, 1);
    issue(0, 2'd2, 1'b1, 3'd1, 32'h1, 32'hFFFFFFFF, 1);
    issue(0, 2'd2, 1'b1, 3'd3, 32'h0, 32'hFFFFFFFF, 1);
    issue(0, 2'd2, 1'b1, 3'd2, 32'(4 * NW), 32'hFFFFFFFF, 1);
    issue(0, 2'd2, 1'b0, 3'd2, 32'h0, 32'h0, 1);
    // BUSY then IDLE between transfers.
    issue(0, 2'd1, 1'b0, 3'd2, 32'h4, 32'h0, 1);
    issue(0, 2'd0, 1'b0, 3'd2, 32'h8, 32'h0, 1);
    issue(0, 2'd2, 1'b0, 3'd2, 32'h4, 32'h0, 1);
    issue(0, 2'd0, 1'b0, 3'd2, 32'h0, 32'h0, 1);

    // Wait-state read, then a write abandoned by reset while it waits.
    issue(1, 2'd2, 1'b0, 3'd2, 32'h0, 32'h0, 1);
    issue(1, 2'd0, 1'b0, 3'd2, 32'h0, 32'h0, 1);
    repeat (4) @(posedge hclk);
    #1;
    issue(1, 2'd2, 1'b1, 3'd2, 32'h40, 32'hCAFEF00D, 0);
    htrans[1] = 2'd0;
    reset[1] = 1'b1;
    @(posedge hclk); #1;
    reset[1] = 1'b0;
    chk("post_reset_hready", 1, 32'(hready[1]), 32'h1);
    chk("post_reset_hresp", 1, 32'(hresp[1]), 32'h0);
    issue(1, 2'd2, 1'b0, 3'd2, 32'h40, 32'h0, 1);

    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 250; n++) begin
        r  = $urandom_range(0, 9);
        tr = (r == 0) ? 2'd0 : (r == 1) ? 2'd1 : (r < 6) ? 2'd2 : 2'd3;
        sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        addr = ($urandom_range(0, 15) == 0) ? 32'(4 * NW + $urandom_range(0, 63))
                                            : 32'($urandom_range(0, 4 * NW - 1));
        if (sz <= 3'd2 && $urandom_range(0, 3) != 0) addr = addr & ~((32'h1 << sz) - 32'h1);
        issue(d, tr, 1'($urandom_range(0, 1)), sz, addr, $urandom, 1);
      end
      issue(d, 2'd0, 1'b0, 3'd2, 32'h0, 32'h0, 1);
    end

    repeat (6) @(posedge hclk);
    #1;
    chk("sb_drained", 0, 32'(sb0.size()), 32'h0);
    chk("sb_drained", 1, 32'(sb1.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
